// File: rtl/tt_demux_4.sv
// tt_demux_4: 1-to-4 word router with per-channel holding registers and delivery/drop counters
module tt_demux_4 #(
    parameter int DW = 32,
    parameter int CW = 16,
    parameter int DROP_WHEN_FULL = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [1:0]    in_sel,
    input  logic [DW-1:0] in_data,
    input  logic [3:0]    ch_en,
    output logic [3:0]    out_valid,
    input  logic [3:0]    out_ready,
    output logic [DW-1:0] out_data0,
    output logic [DW-1:0] out_data1,
    output logic [DW-1:0] out_data2,
    output logic [DW-1:0] out_data3,
    input  logic          cnt_clr,
    output logic [CW-1:0] cnt0,
    output logic [CW-1:0] cnt1,
    output logic [CW-1:0] cnt2,
    output logic [CW-1:0] cnt3,
    output logic [CW-1:0] drop_cnt
);
    logic [DW-1:0] data [4];
    logic [CW-1:0] cnt [4];
    logic full_s, load, drop;

    // a channel draining this cycle counts as free, so a new word can follow with no bubble
    assign full_s   = out_valid[in_sel] & ~out_ready[in_sel];
    assign in_ready = (DROP_WHEN_FULL != 0) | ~ch_en[in_sel] | ~full_s;
    assign load     = in_valid & in_ready & ch_en[in_sel] & ~full_s;
    assign drop     = in_valid & in_ready & ~load;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= '0;
            drop_cnt  <= '0;
            for (int c = 0; c < 4; c++) begin
                data[c] <= '0;
                cnt[c]  <= '0;
            end
        end else begin
            drop_cnt <= cnt_clr ? '0 : drop_cnt + CW'(drop);
            for (int c = 0; c < 4; c++) begin
                out_valid[c] <= (load && in_sel == 2'(c)) | (out_valid[c] & ~out_ready[c]);
                data[c]      <= (load && in_sel == 2'(c)) ? in_data : data[c];
                cnt[c]       <= cnt_clr ? '0 : cnt[c] + CW'(out_valid[c] & out_ready[c]);
            end
        end
    end

    assign out_data0 = data[0];
    assign out_data1 = data[1];
    assign out_data2 = data[2];
    assign out_data3 = data[3];
    assign cnt0 = cnt[0];
    assign cnt1 = cnt[1];
    assign cnt2 = cnt[2];
    assign cnt3 = cnt[3];
endmodule

// File: tb/tb_tt_demux_4.sv
// tb_tt_demux_4: randomized scoreboard bench; backpressure instance (CW=16) and drop-mode instance (CW=4)
module tb_tt_demux_4;
    logic        clk = 0;
    logic        rst_n, in_valid, cnt_clr;
    logic [1:0]  in_sel;
    logic [31:0] in_data;
    logic [3:0]  ch_en, out_ready;

    logic        rdy [2];
    logic [3:0]  val [2];
    logic [31:0] dd  [2][4];
    logic [15:0] c0  [4];
    logic [15:0] dr0;
    logic [3:0]  c1  [4];
    logic [3:0]  dr1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    tt_demux_4 #(.DW(32), .CW(16), .DROP_WHEN_FULL(0)) d0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[0]), .in_sel(in_sel),
        .in_data(in_data), .ch_en(ch_en), .out_valid(val[0]), .out_ready(out_ready),
        .out_data0(dd[0][0]), .out_data1(dd[0][1]), .out_data2(dd[0][2]), .out_data3(dd[0][3]),
        .cnt_clr(cnt_clr), .cnt0(c0[0]), .cnt1(c0[1]), .cnt2(c0[2]), .cnt3(c0[3]), .drop_cnt(dr0)
    );

    tt_demux_4 #(.DW(32), .CW(4), .DROP_WHEN_FULL(1)) d1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[1]), .in_sel(in_sel),
        .in_data(in_data), .ch_en(ch_en), .out_valid(val[1]), .out_ready(out_ready),
        .out_data0(dd[1][0]), .out_data1(dd[1][1]), .out_data2(dd[1][2]), .out_data3(dd[1][3]),
        .cnt_clr(cnt_clr), .cnt0(c1[0]), .cnt1(c1[1]), .cnt2(c1[2]), .cnt3(c1[3]), .drop_cnt(dr1)
    );

    task automatic chk(input string nm, input int m, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d t=%0t: got %h want %h", nm, m, $time, act, exp);
        end
    endtask

    // reference: each channel holds a FIFO of words promised to the consumer (at most one)
    logic [31:0] exp_q [2][4][$];
    logic [31:0] hold  [2][4];
    int          mcnt  [2][4];
    int          mdrop [2];
    bit          armed = 0;

    always @(negedge clk) begin
        for (int m = 0; m < 2; m++) begin
            int  lim;
            bit  full, ok;
            lim = (m == 0) ? 65536 : 16;
            if (armed) begin
                for (int c = 0; c < 4; c++) begin
                    chk("cnt", m, (m == 0) ? 32'(c0[c]) : 32'(c1[c]), 32'(mcnt[m][c]));
                    chk("valid", m, 32'(val[m][c]), 32'(exp_q[m][c].size() != 0));
                    chk("data", m, dd[m][c], hold[m][c]);
                end
                chk("drop_cnt", m, (m == 0) ? 32'(dr0) : 32'(dr1), 32'(mdrop[m]));
            end
            full = exp_q[m][in_sel].size() != 0 && !out_ready[in_sel];
            ok = (m == 1) || !ch_en[in_sel] || !full;
            if (armed || !rst_n) chk("in_ready", m, 32'(rdy[m]), 32'(ok));
            if (!rst_n) begin
                for (int c = 0; c < 4; c++) begin
                    exp_q[m][c].delete();
                    hold[m][c] = 0;
                    mcnt[m][c] = 0;
                end
                mdrop[m] = 0;
            end else begin
                for (int c = 0; c < 4; c++)
                    if (exp_q[m][c].size() != 0 && out_ready[c]) begin
                        chk("order", m, dd[m][c], exp_q[m][c].pop_front());
                        mcnt[m][c] = (mcnt[m][c] + 1) % lim;
                    end
                if (in_valid && ok) begin
                    if (ch_en[in_sel] && !full) begin
                        exp_q[m][in_sel].push_back(in_data);
                        hold[m][in_sel] = in_data;
                    end else
                        mdrop[m] = (mdrop[m] + 1) % lim;
                end
                if (cnt_clr) begin
                    for (int c = 0; c < 4; c++) mcnt[m][c] = 0;
                    mdrop[m] = 0;
                end
            end
        end
        if (!rst_n) armed = 1;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 0; in_valid = 0; in_sel = 0; in_data = 0;
        ch_en = 4'hF; out_ready = 4'hF; cnt_clr = 0;
        cyc(2);
        rst_n = 1;
        cyc(1);
        in_valid = 1; in_sel = 2; in_data = 32'hDEADBEEF;
        cyc(1);
        in_valid = 0;
        cyc(3);
        out_ready[1] = 0; in_valid = 1; in_sel = 1; in_data = 32'h1111_0001;
        cyc(1);
        in_data = 32'h1111_0002;
        cyc(3);
        out_ready[1] = 1;
        cyc(1);
        in_valid = 0;
        cyc(3);
        out_ready = 4'hE; in_sel = 0; in_valid = 1;
        for (int i = 0; i < 3; i++) begin
            in_data = $urandom;
            cyc(1);
        end
        in_valid = 0;
        cyc(2);
        out_ready = 4'hF;
        cyc(2);
        ch_en = 4'b1110; in_valid = 1; in_sel = 0;
        for (int i = 0; i < 5; i++) begin
            in_data = $urandom;
            cyc(1);
        end
        in_valid = 0; ch_en = 4'hF;
        cyc(2);
        for (int i = 0; i < 1000; i++) begin
            in_valid = 1; in_sel = 2'(i); in_data = $urandom;
            cyc(1);
        end
        in_valid = 0;
        cyc(2);
        cnt_clr = 1;
        cyc(1);
        cnt_clr = 0;
        for (int i = 0; i < 17; i++) begin
            in_valid = 1; in_sel = 3; in_data = $urandom;
            cyc(1);
        end
        in_valid = 0;
        cyc(1);
        in_valid = 1; in_sel = 3; in_data = 32'hC0DE_0003;
        cyc(1);
        in_valid = 0; cnt_clr = 1;
        cyc(1);
        cnt_clr = 0;
        cyc(2);
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            in_sel    = 2'($urandom);
            in_data   = $urandom;
            ch_en     = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'hF;
            out_ready = 4'($urandom);
            cnt_clr   = ($urandom_range(0, 63) == 0);
            rst_n     = ($urandom_range(0, 499) != 0);
            cyc(1);
        end
        rst_n = 1; in_valid = 0; cnt_clr = 0; out_ready = 4'hF; ch_en = 4'hF;
        cyc(3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/tt_demux_4.md
Name: tt_demux_4

Overview:
1-to-4 word router for the time-tagging datapath. Accepts a 32-bit word stream with a 2-bit destination select. Steers each word into one of four output channels, each with a one-entry holding register and a valid/ready handshake. Keeps per-channel delivered-word counters and a dropped-word counter, which the time-tagging register bank reads for diagnostics.

Parameters:
DW, 32, data word width
CW, 16, width of each delivered counter and of the drop counter
DROP_WHEN_FULL, 0, 0 = backpressure the input when the selected channel is full; 1 = input never stalls and words to a full channel are discarded

Ports:
clk  in  1  system clock; all logic rising-edge
rst_n  in  1  synchronous active-low reset
in_valid  in  1  input word valid
in_ready  out  1  input can accept this cycle
in_sel  in  2  destination channel of the input word
in_data  in  DW  input word
ch_en  in  4  per-channel enable; a word sent to a disabled channel is accepted and discarded
out_valid  out  4  per-channel word valid
out_ready  in  4  per-channel consumer ready
out_data0..out_data3  out  DW each  per-channel holding-register contents
cnt_clr  in  1  synchronous clear of all counters
cnt0..cnt3  out  CW each  words delivered per channel (out_valid & out_ready)
drop_cnt  out  CW  words discarded (disabled channel or full in drop mode)

Behaviour:
- Reset (rst_n=0 at a clk edge): out_valid=4'b0000; out_data0..3=0; cnt0..3=0; drop_cnt=0. in_ready is combinational and follows the rules below, so it is 1 during reset in both modes.
- Input handshake: a word is accepted when in_valid & in_ready at a clk edge.
- Let s = in_sel. Let full_s = out_valid[s] & ~out_ready[s].
- DROP_WHEN_FULL=0: in_ready = ~ch_en[s] | ~full_s. The channel is freed in the same cycle it drains (pass-through); no bubble.
- DROP_WHEN_FULL=1: in_ready = 1 always.
- Accepted word with ch_en[s]=1 and ~full_s:
  - out_data_s <= in_data; out_valid[s] <= 1 on the next edge.
  - Latency: 1 cycle from acceptance to out_valid.
- Accepted word with ch_en[s]=0, or with full_s in drop mode:
  - Word discarded; holding register unchanged.
  - drop_cnt increments.
- Output handshake per channel c: on out_valid[c] & out_ready[c], cnt_c increments. out_valid[c] clears unless a new word is loaded into c on the same edge; if loaded, it stays 1 with the new data.
- Holding register is stable while out_valid[c]=1 & out_ready[c]=0: data and valid must not change.
- ch_en deasserted while out_valid[c]=1: the held word is still delivered normally. Enable gates only new arrivals.
- Only one channel can be loaded per cycle; any number of channels can drain per cycle.
- Counters:
  - All counters wrap modulo 2^CW.
  - cnt_clr has priority over increments in the same cycle: the counter result is 0 and the coincident event is not counted.
  - cnt_clr does not affect data or valid.
- in_sel, in_data and ch_en are sampled only on an accepting edge.
- Reset mid-transfer: held words are lost, no counts are recorded, and in_ready is re-evaluated the next cycle.
- Structure: no combinational path from in_* to out_*. The only combinational paths are out_ready/out_valid/ch_en/in_sel -> in_ready.

Test Plan:
- Reset then single word: in_sel=2, in_data=32'hDEADBEEF, ch_en=4'hF, out_ready=4'hF -> next cycle out_valid=4'b0100, out_data2=32'hDEADBEEF; cnt2=1 after the following edge; other counters 0.
- Backpressure (DROP_WHEN_FULL=0): out_ready[1]=0, send two words to ch1 -> first is held, in_ready=0 for the second; raise out_ready[1] -> in_ready=1 that cycle, second word loads with no bubble, cnt1=1 then 2.
- Drop mode (DROP_WHEN_FULL=1): out_ready[0]=0, send 3 words to ch0 -> in_ready stays 1, out_data0 = first word, drop_cnt=2, cnt0=0 until drained.
- Disabled channel: ch_en=4'b1110, send 5 words to ch0 -> all accepted, out_valid[0] never asserts, drop_cnt=5.
- Round-robin streaming: 1000 back-to-back words with in_sel cycling 0..3, all ready -> one word per cycle, cnt0..3=250 each, order preserved per channel.
- Counter edges: CW=4, 17 deliveries on ch3 -> cnt3=1 (wrap); assert cnt_clr coincident with a delivery -> cnt3=0, and out_valid/out_data3 are unaffected.
